// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default constants for the instruction-fetch
//               sequencer and its PC register.
//               Exports:
//                 XLEN              - datapath / PC width
//                 RESET_VECTOR_DEF  - default PC after reset
//                 TRAP_VECTOR_DEF   - default PC target on trap
//                 PC_INC_DEF        - default sequential PC increment (bytes)
//                 fetch_state_e     - IDLE / FETCH / HOLD sequencer states
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam logic [XLEN-1:0] PC_INC_DEF       = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program-counter register. Loads a new target (already word
//               aligned by the caller) or advances by PC_INC; load wins when
//               both are requested. Increment wraps modulo 2^XLEN.
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous active-high reset (PC=RESET_VECTOR)
//               load_i      - load load_addr_i into the PC
//               load_addr_i - new PC value (word aligned)
//               inc_i       - advance PC by PC_INC
//               pc_o        - current PC
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] PC_INC       = PC_INC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      // Natural XLEN-bit overflow gives the required wrap to zero.
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch controller. Owns the PC, issues single-
//               outstanding req/ack fetches to instruction memory, holds each
//               returned word toward decode with a valid/ready handshake, and
//               applies branch redirects and traps (trap has priority).
//               Fetch data belonging to a request that was overtaken by a
//               flush is discarded.
// Ports       : clk, rst          - clock / async active-high reset
//               fetch_en_i        - permits new fetches to start
//               imem_req_o        - fetch request (high while in FETCH)
//               imem_addr_o       - fetch address (= PC)
//               imem_ack_i        - single-cycle response strobe
//               imem_rdata_i      - returned instruction word
//               if_valid_o        - held instruction valid toward decode
//               if_ready_i        - decode accepts held instruction
//               if_instr_o        - held instruction
//               if_pc_o           - PC of held instruction
//               redirect_valid_i  - branch / jump redirect
//               redirect_addr_i   - redirect target
//               trap_i            - trap request
//               misalign_err_o    - one-cycle pulse on misaligned redirect
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter logic [XLEN-1:0] PC_INC       = PC_INC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  input  logic            trap_i,
  output logic            misalign_err_o
);

  fetch_state_e    state_q;
  logic            req_q;
  logic            valid_q;
  logic            discard_q;
  logic            misalign_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] ipc_q;

  logic            flush;
  logic [XLEN-1:0] flush_target;
  logic            pc_inc;
  logic [XLEN-1:0] pc;

  assign flush        = trap_i | redirect_valid_i;
  assign flush_target = trap_i ? TRAP_VECTOR : {redirect_addr_i[XLEN-1:2], 2'b00};

  // Advance only when a live (non-stale) response is captured.
  assign pc_inc = (state_q == FETCH) & imem_ack_i & ~discard_q & ~flush;

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR),
    .PC_INC       (PC_INC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (flush),
    .load_addr_i (flush_target),
    .inc_i       (pc_inc),
    .pc_o        (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      discard_q  <= 1'b0;
      misalign_q <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= '0;
    end else begin
      misalign_q <= redirect_valid_i & ~trap_i & (|redirect_addr_i[1:0]);

      case (state_q)
        IDLE: begin
          if (flush || fetch_en_i) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end

        FETCH: begin
          if (flush) begin
            // Without an ack this cycle the old request is still in flight,
            // so its eventual response must be thrown away. An ack arriving
            // together with the flush is dropped here and leaves nothing
            // outstanding.
            discard_q <= ~imem_ack_i;
          end else if (imem_ack_i) begin
            if (discard_q) begin
              discard_q <= 1'b0;
            end else begin
              instr_q <= imem_rdata_i;
              ipc_q   <= pc;
              state_q <= HOLD;
              req_q   <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (flush) begin
            // Held instruction is dropped even if decode is ready.
            state_q <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (if_ready_i) begin
            valid_q <= 1'b0;
            if (fetch_en_i) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o     = req_q;
  assign imem_addr_o    = pc;
  assign if_valid_o     = valid_q;
  assign if_instr_o     = instr_q;
  assign if_pc_o        = ipc_q;
  assign misalign_err_o = misalign_q;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. A latency-driven
//               memory responder, an address scoreboard (expected request
//               addresses) and an instruction scoreboard (expected pc/instr
//               at each decode accept), plus a table of flush scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        tr;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } flush_vec_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  exp_t        mon_e;
  flush_vec_t  vecs[6];

  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  int          mem_lat  = 2;
  logic [31:0] mem_addr = '0;
  logic [31:0] cur_pc;
  logic [31:0] a_tmp;

  fetch_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .PC_INC       (32'd4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en_i       (fetch_en),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .redirect_valid_i (redirect_valid),
    .redirect_addr_i  (redirect_addr),
    .trap_i           (trap),
    .misalign_err_o   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input bit accepted);
    addr_q.push_back(a);
    if (accepted) exp_q.push_back('{pc: a, instr: word_of(a)});
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!if_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, 96'(if_valid), 96'(1));
  endtask

  task automatic wait_req(input string nm, input logic [31:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_req && imem_addr == a) && n < 40);
    check(nm, 96'({imem_req, imem_addr}), 96'({1'b1, a}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; trap = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Memory responder: latches the address when it sees a new request and
  // pulses ack mem_lat cycles later with data for that latched address.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = word_of(mem_addr);
          mem_busy   = 1'b0;
        end
      end else if (imem_req) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = mem_lat;
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_addr: got unexpected request at %h, none required", imem_addr);
        end else begin
          a_tmp = addr_q.pop_front();
          check("req_addr", 96'(imem_addr), 96'(a_tmp));
        end
      end
    end
  end

  // Decode-side monitor: inputs are settled 1 unit after the falling edge.
  always @(negedge clk) begin
    #1;
    if (!rst && if_valid && if_ready && !redirect_valid && !trap) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL accept: got instr %h pc %h, none required", if_instr, if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("accept_pc", 96'(if_pc), 96'(mon_e.pc));
        check("accept_instr", 96'(if_instr), 96'(mon_e.instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nvalid;
    int viol;
    rst = 1'b1; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0; trap = 1'b0;

    vecs[0] = '{rv: 1'b1, ra: 32'h0000_0080, tr: 1'b1, exp_addr: 32'h0000_0100, exp_mis: 1'b0};
    vecs[1] = '{rv: 1'b1, ra: 32'h0000_0043, tr: 1'b0, exp_addr: 32'h0000_0040, exp_mis: 1'b1};
    vecs[2] = '{rv: 1'b0, ra: 32'h0000_0043, tr: 1'b1, exp_addr: 32'h0000_0100, exp_mis: 1'b0};
    vecs[3] = '{rv: 1'b1, ra: 32'h0000_1002, tr: 1'b0, exp_addr: 32'h0000_1000, exp_mis: 1'b1};
    vecs[4] = '{rv: 1'b1, ra: 32'h0000_0200, tr: 1'b0, exp_addr: 32'h0000_0200, exp_mis: 1'b0};
    vecs[5] = '{rv: 1'b1, ra: 32'hFFFF_FFFC, tr: 1'b0, exp_addr: 32'hFFFF_FFFC, exp_mis: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req",   96'(imem_req),     96'(0));
    check("rst_valid", 96'(if_valid),     96'(0));
    check("rst_instr", 96'(if_instr),     96'(0));
    check("rst_pc",    96'(if_pc),        96'(0));
    check("rst_mis",   96'(misalign_err), 96'(0));
    check("rst_addr",  96'(imem_addr),    96'(32'h0000_0000));

    // Sequential stream 0x0, 0x4, 0x8 with decode always ready
    push_fetch(32'h0, 1'b1);
    push_fetch(32'h4, 1'b1);
    push_fetch(32'h8, 1'b1);
    rst = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    nvalid = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_valid) begin
        nvalid++;
        if (nvalid == 3) fetch_en = 1'b0;
      end
    end
    check("seq_valid_cycles", 96'(nvalid), 96'(3));
    check("seq_accepts", 96'(n_acc), 96'(3));
    check("seq_idle_req", 96'(imem_req), 96'(0));

    // Back-pressure in HOLD, then accept with fetch_en low / high
    do_reset();
    push_fetch(32'h0, 1'b1);
    fetch_en = 1'b1; if_ready = 1'b0;
    wait_valid("hold_valid");
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_stable", 96'({if_valid, if_instr, if_pc}), 96'({1'b1, 32'h13, 32'h0}));
      @(negedge clk);
    end
    if_ready = 1'b1;
    @(negedge clk);
    check("accept_to_idle", 96'({imem_req, if_valid}), 96'(0));
    if_ready = 1'b0;
    push_fetch(32'h4, 1'b1);
    fetch_en = 1'b1;
    wait_valid("hold2_valid");
    push_fetch(32'h8, 1'b1);
    if_ready = 1'b1;
    @(negedge clk);
    check("accept_to_fetch", 96'({imem_req, imem_addr, if_valid}), 96'({1'b1, 32'h8, 1'b0}));
    fetch_en = 1'b0;
    wait_valid("no_abort_valid");
    @(negedge clk);
    check("no_abort_idle", 96'({imem_req, if_valid}), 96'(0));
    if_ready = 1'b0;

    // Redirect while the request for 0x8 is outstanding
    do_reset();
    push_fetch(32'h0, 1'b1);
    push_fetch(32'h4, 1'b1);
    push_fetch(32'h8, 1'b0);
    push_fetch(32'h40, 1'b1);
    fetch_en = 1'b1; if_ready = 1'b1;
    wait_req("see_req8", 32'h8);
    redirect_valid = 1'b1; redirect_addr = 32'h40; fetch_en = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_addr", 96'({imem_req, imem_addr, if_valid}), 96'({1'b1, 32'h40, 1'b0}));
    check("redir_mis", 96'(misalign_err), 96'(0));
    repeat (2) @(negedge clk);
    check("stale_drop", 96'({imem_req, imem_addr, if_valid}), 96'({1'b1, 32'h40, 1'b0}));
    wait_valid("redir_valid");
    @(negedge clk);
    if_ready = 1'b0;
    cur_pc = 32'h44;

    // Flush table: each entry flushes an instruction held in HOLD while
    // decode is ready, then lets the refetch complete and be accepted.
    for (int i = 0; i < 6; i++) begin
      push_fetch(cur_pc, 1'b0);
      fetch_en = 1'b1; if_ready = 1'b0;
      wait_valid("tbl_hold");
      fetch_en = 1'b0; if_ready = 1'b1;
      redirect_valid = vecs[i].rv; redirect_addr = vecs[i].ra; trap = vecs[i].tr;
      push_fetch(vecs[i].exp_addr, 1'b1);
      @(negedge clk);
      redirect_valid = 1'b0; trap = 1'b0;
      check("tbl_flush", 96'({imem_req, imem_addr, if_valid}), 96'({1'b1, vecs[i].exp_addr, 1'b0}));
      check("tbl_mis", 96'(misalign_err), 96'(vecs[i].exp_mis));
      @(negedge clk);
      check("tbl_mis_clr", 96'(misalign_err), 96'(0));
      wait_valid("tbl_refetch");
      @(negedge clk);
      if_ready = 1'b0;
      cur_pc = vecs[i].exp_addr + 32'd4;
    end

    // After accepting 0xFFFF_FFFC the PC must have wrapped to 0
    push_fetch(32'h0, 1'b1);
    fetch_en = 1'b1; if_ready = 1'b1;
    wait_req("wrap_addr", 32'h0);
    fetch_en = 1'b0;
    wait_valid("wrap_valid");
    @(negedge clk);

    // Asynchronous reset in the middle of a fetch; the late ack is ignored
    push_fetch(32'h4, 1'b0);
    fetch_en = 1'b1;
    wait_req("rstmid_req", 32'h4);
    fetch_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rstmid_async", 96'({imem_req, imem_addr, if_valid}), 96'({1'b0, 32'h0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req || if_valid) viol++;
    end
    check("stale_ack_ignored", 96'(viol), 96'(0));

    // Fetching resumes from the reset vector
    push_fetch(32'h0, 1'b1);
    fetch_en = 1'b1;
    wait_valid("post_rst_valid");
    fetch_en = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drain", 96'(exp_q.size()), 96'(0));
    check("addr_drain", 96'(addr_q.size()), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_sequencer
`default_nettype wire
